// File: rtl/mimo_input_loader_pkg.sv
// Shared word-length and frame-geometry parameters for the MIMO input loader.
// One frame carries an 8x8 real channel matrix H and an 8-element receive vector Y.
package mimo_input_loader_pkg;

    localparam int WL      = 15;
    localparam int H_WORDS = 64;
    localparam int Y_WORDS = 8;
    localparam int CNT_W   = 7;
    localparam int Y_IDX_W = 3;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_WORDS - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(Y_WORDS - 1);

    function automatic logic [CNT_W-1:0] cntInc(input logic [CNT_W-1:0] c);
        return c + CNT_ONE;
    endfunction

endpackage

// File: rtl/mimo_input_loader.sv
// Streams H (64 words) and Y (8 words) into shadow storage, then commits them atomically
// to the output registers so downstream logic always sees a complete, consistent frame.
module mimo_input_loader
    import mimo_input_loader_pkg::H_WORDS;
    import mimo_input_loader_pkg::Y_WORDS;
    import mimo_input_loader_pkg::CNT_W;
    import mimo_input_loader_pkg::Y_IDX_W;
    import mimo_input_loader_pkg::CNT_ZERO;
    import mimo_input_loader_pkg::CNT_ONE;
    import mimo_input_loader_pkg::H_LAST;
    import mimo_input_loader_pkg::Y_LAST;
    import mimo_input_loader_pkg::cntInc;
#(
    parameter int WL = mimo_input_loader_pkg::WL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WL-1:0]           in_data,
    input  logic                    in_last,
    input  logic                    reuse_h,
    output logic [H_WORDS*WL-1:0]   Hmatrix_o,
    output logic [Y_WORDS*WL-1:0]   Yarray_o,
    output logic                    out_valid,
    output logic                    frame_err
);

    typedef enum logic [1:0] {
        LOAD_H = 2'd0,
        LOAD_Y = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [H_WORDS*WL-1:0]  hShadow_q;
    logic [Y_WORDS*WL-1:0]  yShadow_q;
    logic [H_WORDS*WL-1:0]  hOut_q;
    logic [Y_WORDS*WL-1:0]  yOut_q;
    logic                   outValid_q;
    logic                   frameErr_q;

    logic                   accept;
    logic                   wrH;
    logic                   wrY;
    logic                   reloadH;
    logic                   errSet;
    logic                   commitEn;
    logic [Y_IDX_W-1:0]     yIdx;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD_H;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrH     = 1'b0;
        wrY     = 1'b0;
        reloadH = 1'b0;
        errSet  = 1'b0;
        yIdx    = cnt_q[Y_IDX_W-1:0];

        case (state_q)
            LOAD_H: begin
                if (accept) begin
                    // A Y-only frame reuses the committed H, so its first word is Y element 0.
                    if (cnt_q == CNT_ZERO && reuse_h) begin
                        reloadH = 1'b1;
                        wrY     = 1'b1;
                        yIdx    = '0;
                        if (in_last) begin
                            errSet = 1'b1;
                        end else begin
                            state_d = LOAD_Y;
                            cnt_d   = CNT_ONE;
                        end
                    end else begin
                        wrH = 1'b1;
                        if (in_last) begin
                            errSet = 1'b1;
                            cnt_d  = CNT_ZERO;
                        end else if (cnt_q == H_LAST) begin
                            state_d = LOAD_Y;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d = cntInc(cnt_q);
                        end
                    end
                end
            end
            LOAD_Y: begin
                if (accept) begin
                    wrY = 1'b1;
                    // The final Y word always commits; a missing in_last is only flagged.
                    if (cnt_q == Y_LAST) begin
                        errSet  = !in_last;
                        state_d = COMMIT;
                        cnt_d   = CNT_ZERO;
                    end else if (in_last) begin
                        errSet  = 1'b1;
                        state_d = LOAD_H;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cntInc(cnt_q);
                    end
                end
            end
            COMMIT: begin
                state_d = LOAD_H;
                cnt_d   = CNT_ZERO;
            end
            default: begin
                state_d = LOAD_H;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Ready is gated by rst directly so no word can be accepted while reset is held.
    always_comb begin
        in_ready = rst && (state_q != COMMIT);
        commitEn = (state_q == COMMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hShadow_q  <= '0;
            yShadow_q  <= '0;
            hOut_q     <= '0;
            yOut_q     <= '0;
            outValid_q <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            if (reloadH) begin
                hShadow_q <= hOut_q;
            end
            if (wrH) begin
                hShadow_q[int'(cnt_q)*WL +: WL] <= in_data;
            end
            if (wrY) begin
                yShadow_q[int'(yIdx)*WL +: WL] <= in_data;
            end
            if (commitEn) begin
                hOut_q <= hShadow_q;
                yOut_q <= yShadow_q;
            end
            outValid_q <= commitEn;
            frameErr_q <= frameErr_q | errSet;
        end
    end

    assign Hmatrix_o = hOut_q;
    assign Yarray_o  = yOut_q;
    assign out_valid = outValid_q;
    assign frame_err = frameErr_q;

endmodule
